// File: rtl/fifo_pkg.sv
// Shared types and constants for the single-clock FIFO family.
// Holds defaults, count-width helper and the upstream status bundle.
package fifo_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 3;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic empty;
    logic full;
    logic almost_empty;
    logic almost_full;
  } fifo_status_t;

endpackage

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: synchronous write, registered read port.
// Read register resets to zero and holds when no read is issued.
module fifo_sdp_ram #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // storage array write, never cleared
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with count and threshold flags.
// Sticky overflow/underflow built only with SYNC_FIFO_ERR_FLAG_EN.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  wdata_vld,
  input  logic                  rdata_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_vld,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  err_clr,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int CW    = cnt_width(DEPTH);

  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_T   = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_T   = CW'(AE_THRESH);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt_q;
  logic          wr_acc;
  logic          rd_acc;
  fifo_status_t  st;
  logic          unused_ptr_msb;

  assign st.empty        = (cnt_q == '0);
  assign st.full         = (cnt_q == FULL_C);
  assign st.almost_empty = (cnt_q <= AE_T);
  assign st.almost_full  = (cnt_q >= AF_T);

  assign empty        = st.empty;
  assign full         = st.full;
  assign almost_empty = st.almost_empty;
  assign almost_full  = st.almost_full;
  assign count        = cnt_q;

  assign wr_acc = wdata_vld & ~st.full  & ~rst;
  assign rd_acc = rdata_en  & ~st.empty & ~rst;

  assign unused_ptr_msb = wptr[PW-1] ^ rptr[PW-1];

  fifo_sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wptr[ADDR_WIDTH-1:0]),
    .wdata (wdata),
    .re    (rd_acc),
    .raddr (rptr[ADDR_WIDTH-1:0]),
    .rdata (rdata)
  );

  // pointers advance on accepted requests and wrap at 2*DEPTH
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + PW'(1);
      if (rd_acc) rptr <= rptr + PW'(1);
    end
  end

  // occupancy and read-valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      rdata_vld <= 1'b0;
    end else begin
      rdata_vld <= rd_acc;
      unique case ({wr_acc, rd_acc})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef SYNC_FIFO_ERR_FLAG_EN
  logic ovf_q;
  logic udf_q;

  assign overflow  = ovf_q;
  assign underflow = udf_q;

  // sticky error flags; a new error beats a same-cycle clear
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (wdata_vld & st.full) ovf_q <= 1'b1;
      else if (err_clr)        ovf_q <= 1'b0;
      if (rdata_en & st.empty) udf_q <= 1'b1;
      else if (err_clr)        udf_q <= 1'b0;
    end
  end
`else
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule
